// File: rtl/router_pkt_tx_if.sv
// Host-side and router-side signals of the packet transmitter.
// The slave modport is the transmitter; the master modport is the host and the router.
interface router_pkt_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       buf_full;
  logic [5:0] buf_count;
  logic       start;
  logic [1:0] dest;
  logic       tx_busy;
  logic       tx_done;
  logic       err;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       busy;

  modport master (
    output wr_en, wr_data, start, dest, busy,
    input  buf_full, buf_count, tx_busy, tx_done, err, data_in, pkt_valid
  );

  modport slave (
    input  wr_en, wr_data, start, dest, busy,
    output buf_full, buf_count, tx_busy, tx_done, err, data_in, pkt_valid
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Transmit engine for the 1x3 router input port: buffers host payload bytes, then
// serialises header, payload and parity, holding the current byte while busy is high.
module router_pkt_tx #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic           clk,
  input  logic           reset,
  router_pkt_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;

  state_t        state_q;
  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, cnt_q, len_q, rem_q;
  logic [DW-1:0] data_q, par_q;
  logic          vld_q, tx_busy_q, tx_done_q, err_q;
  logic          start_ok_d, wr_ok_d, accept_d;
  logic [DW-1:0] rd_byte_d;

  // A write in the cycle of an accepted start would corrupt the latched length, so it is dropped.
  assign start_ok_d = (state_q == IDLE) && bus.start && (bus.dest != 2'd3) && (cnt_q != '0);
  assign wr_ok_d    = bus.wr_en && (state_q == IDLE) && (cnt_q != '1) && !start_ok_d;
  assign accept_d   = (state_q != IDLE) && !bus.busy;
  assign rd_byte_d  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_ok_d) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      err_q     <= 1'b0;
      if (wr_ok_d) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        cnt_q    <= cnt_q + AW'(1);
      end
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (start_ok_d) begin
              state_q   <= HEADER;
              len_q     <= cnt_q;
              data_q    <= {cnt_q, bus.dest};
              par_q     <= {cnt_q, bus.dest};
              vld_q     <= 1'b1;
              tx_busy_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        HEADER: begin
          if (accept_d) begin
            state_q  <= PAYLOAD;
            data_q   <= rd_byte_d;
            par_q    <= par_q ^ rd_byte_d;
            rd_ptr_q <= rd_ptr_q + AW'(1);
            rem_q    <= len_q - AW'(1);
          end
        end
        PAYLOAD: begin
          // rem_q counts bytes still to load after the one currently on the bus.
          if (accept_d) begin
            if (rem_q != '0) begin
              data_q   <= rd_byte_d;
              par_q    <= par_q ^ rd_byte_d;
              rd_ptr_q <= rd_ptr_q + AW'(1);
              rem_q    <= rem_q - AW'(1);
            end else begin
              state_q <= PARITY;
              data_q  <= par_q;
              vld_q   <= 1'b0;
            end
          end
        end
        PARITY: begin
          if (accept_d) begin
            state_q   <= IDLE;
            data_q    <= '0;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b1;
            cnt_q     <= cnt_q - len_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.buf_full  = (cnt_q == '1);
  assign bus.buf_count = cnt_q;
  assign bus.tx_busy   = tx_busy_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.err       = err_q;
  assign bus.data_in   = data_q;
  assign bus.pkt_valid = vld_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: a byte-queue model of the buffer predicts
// each packet (header, payload, parity) which is compared with the bytes accepted on the bus.
module tb_router_pkt_tx;
  logic clk = 1'b0;
  logic reset;
  router_pkt_tx_if bus();

  router_pkt_tx #(.AW(6), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  byte unsigned model_q[$];

  task automatic load_byte(input byte unsigned b, input string nm);
    logic [5:0] exp_cnt;
    logic       exp_full;
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (model_q.size() < 63) model_q.push_back(b);
    exp_cnt  = 6'(model_q.size());
    exp_full = (model_q.size() == 63);
    total++;
    if (bus.buf_count !== exp_cnt) begin
      bad++;
      $display("FAIL %s buf_count got=%0d want=%0d", nm, bus.buf_count, exp_cnt);
    end
    total++;
    if (bus.buf_full !== exp_full) begin
      bad++;
      $display("FAIL %s buf_full got=%0b want=%0b", nm, bus.buf_full, exp_full);
    end
  endtask

  task automatic run_packet(input logic [1:0] d, input int busy_pct, input int hold_idx,
                            input int hold_len, input bit wr_during, input bit wr_at_start,
                            input bit start_during, input string nm);
    byte unsigned exp[$];
    logic [8:0]   got[$];
    logic [8:0]   want;
    logic [5:0]   l6;
    logic [7:0]   hdr, par, prev_d;
    logic         prev_v, vbit;
    int           cyc, held;
    bit           done_seen, was_busy, err_seen;
    l6  = 6'(model_q.size());
    hdr = {l6, d};
    par = hdr;
    exp.push_back(hdr);
    foreach (model_q[i]) begin
      exp.push_back(model_q[i]);
      par ^= model_q[i];
    end
    exp.push_back(par);

    bus.start = 1'b1;
    bus.dest  = d;
    bus.busy  = 1'b0;
    if (wr_at_start) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hA5;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    total++;
    if ({bus.pkt_valid, bus.data_in, bus.tx_busy} !== {1'b1, hdr, 1'b1}) begin
      bad++;
      $display("FAIL %s header_latency got vld=%0b data=%02h txb=%0b want vld=1 data=%02h txb=1",
               nm, bus.pkt_valid, bus.data_in, bus.tx_busy, hdr);
    end

    cyc = 0; held = 0; done_seen = 0; err_seen = 0;
    while (!done_seen && cyc < 3000) begin
      if (hold_idx >= 0 && got.size() == hold_idx && held < hold_len) begin
        bus.busy = 1'b1;
        held++;
      end else begin
        bus.busy = (int'($urandom_range(99)) < busy_pct) ? 1'b1 : 1'b0;
      end
      if (wr_during) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'($urandom);
      end
      if (start_during) begin
        bus.start = 1'($urandom_range(1));
        bus.dest  = 2'($urandom);
      end
      was_busy = bus.busy;
      prev_d   = bus.data_in;
      prev_v   = bus.pkt_valid;
      if (bus.tx_busy && !bus.busy) got.push_back({bus.pkt_valid, bus.data_in});
      @(negedge clk);
      cyc++;
      if (bus.err) err_seen = 1;
      if (bus.tx_done) done_seen = 1;
      else if (was_busy) begin
        total++;
        if ({bus.pkt_valid, bus.data_in} !== {prev_v, prev_d}) begin
          bad++;
          $display("FAIL %s stall_hold got vld=%0b data=%02h want vld=%0b data=%02h",
                   nm, bus.pkt_valid, bus.data_in, prev_v, prev_d);
        end
      end
    end
    bus.busy  = 1'b0;
    bus.wr_en = 1'b0;
    bus.start = 1'b0;

    total++;
    if (!done_seen) begin
      bad++;
      $display("FAIL %s timeout got cycles=%0d want tx_done", nm, cyc);
    end
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL %s byte_count got=%0d want=%0d", nm, got.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        vbit = (i < exp.size() - 1);
        want = {vbit, exp[i]};
        total++;
        if (got[i] !== want) begin
          bad++;
          $display("FAIL %s byte[%0d] got vld=%0b data=%02h want vld=%0b data=%02h",
                   nm, i, got[i][8], got[i][7:0], want[8], want[7:0]);
        end
      end
    end
    if (busy_pct == 0 && hold_idx < 0) begin
      total++;
      if (cyc != exp.size()) begin
        bad++;
        $display("FAIL %s bus_cycles got=%0d want=%0d", nm, cyc, exp.size());
      end
    end
    total++;
    if ({bus.tx_busy, bus.pkt_valid, bus.data_in, bus.buf_count} !== {1'b0, 1'b0, 8'h00, 6'd0}) begin
      bad++;
      $display("FAIL %s after_done got txb=%0b vld=%0b data=%02h cnt=%0d want 0 0 00 0",
               nm, bus.tx_busy, bus.pkt_valid, bus.data_in, bus.buf_count);
    end
    total++;
    if (err_seen) begin
      bad++;
      $display("FAIL %s err_during_tx got=1 want=0", nm);
    end
    model_q.delete();
    @(negedge clk);
    total++;
    if (bus.tx_done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_pulse_width got=%0b want=0", nm, bus.tx_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.pkt_valid, bus.data_in, bus.tx_busy, bus.tx_done, bus.err} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got vld=%0b data=%02h txb=%0b done=%0b err=%0b want all 0",
               bus.pkt_valid, bus.data_in, bus.tx_busy, bus.tx_done, bus.err);
    end
    total++;
    if ({bus.buf_full, bus.buf_count} !== 7'd0) begin
      bad++;
      $display("FAIL reset_buffer got full=%0b cnt=%0d want 0 0", bus.buf_full, bus.buf_count);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_byte(8'h11, "basic_load");
    load_byte(8'h22, "basic_load");
    load_byte(8'h33, "basic_load");
    run_packet(2'd1, 0, -1, 0, 1'b0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_stall();
    load_byte(8'h11, "stall_load");
    load_byte(8'h22, "stall_load");
    load_byte(8'h33, "stall_load");
    run_packet(2'd2, 0, 2, 4, 1'b0, 1'b0, 1'b0, "stall");
  endtask

  task automatic test_err();
    bus.start = 1'b1;
    bus.dest  = 2'd1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if ({bus.err, bus.pkt_valid, bus.tx_busy} !== 3'b100) begin
      bad++;
      $display("FAIL err_empty got err=%0b vld=%0b txb=%0b want 1 0 0", bus.err, bus.pkt_valid, bus.tx_busy);
    end
    @(negedge clk);
    total++;
    if (bus.err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse_width got=%0b want=0", bus.err);
    end
    load_byte(8'h5A, "err_load");
    bus.start = 1'b1;
    bus.dest  = 2'd3;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if ({bus.err, bus.pkt_valid, bus.tx_busy, bus.buf_count} !== {3'b100, 6'd1}) begin
      bad++;
      $display("FAIL err_dest3 got err=%0b vld=%0b txb=%0b cnt=%0d want 1 0 0 1",
               bus.err, bus.pkt_valid, bus.tx_busy, bus.buf_count);
    end
    @(negedge clk);
    run_packet(2'd0, 0, -1, 0, 1'b0, 1'b0, 1'b0, "after_err");
  endtask

  task automatic test_full();
    for (int i = 0; i < 64; i++) load_byte(8'($urandom), "full_load");
    run_packet(2'($urandom_range(2)), 20, -1, 0, 1'b0, 1'b0, 1'b0, "full");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) load_byte(8'($urandom), "rst_load");
    bus.start = 1'b1;
    bus.dest  = 2'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.busy = 1'b1;
    @(negedge clk);
    bus.busy = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({bus.pkt_valid, bus.data_in, bus.buf_count, bus.tx_busy, bus.tx_done} !== 17'd0) begin
      bad++;
      $display("FAIL reset_mid got vld=%0b data=%02h cnt=%0d txb=%0b done=%0b want all 0",
               bus.pkt_valid, bus.data_in, bus.buf_count, bus.tx_busy, bus.tx_done);
    end
    model_q.delete();
    load_byte(8'hC3, "post_rst_load");
    run_packet(2'd1, 0, -1, 0, 1'b0, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_wr_drop();
    for (int i = 0; i < 4; i++) load_byte(8'($urandom), "drop_load");
    run_packet(2'($urandom_range(2)), 30, -1, 0, 1'b1, 1'b1, 1'b1, "wr_drop");
  endtask

  task automatic test_random();
    int n;
    for (int p = 0; p < 6; p++) begin
      n = int'($urandom_range(20, 1));
      for (int i = 0; i < n; i++) load_byte(8'($urandom), "rand_load");
      run_packet(2'($urandom_range(2)), int'($urandom_range(60)), -1, 0, 1'b0, 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.start   = 1'b0;
    bus.dest    = 2'd0;
    bus.busy    = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_err();
    test_full();
    test_reset_mid();
    test_wr_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
